// File: rtl/pointwise_div.sv
// Element-wise signed fixed-point divider: out[i] = vector1[i] / vector2[i], one shared restoring divider.
// WIDTH+FRAC+2 cycles per element; start accepted only in IDLE, busy/done/overflow registered.
`ifndef MAX_NEURONS
`define MAX_NEURONS 4
`endif

module pointwise_div #(
  parameter int MAX_NEURONS = `MAX_NEURONS,
  parameter int WIDTH       = 16,
  parameter int FRAC        = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [MAX_NEURONS*WIDTH-1:0] vector1,
  input  logic [MAX_NEURONS*WIDTH-1:0] vector2,
  output logic [MAX_NEURONS*WIDTH-1:0] out,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow
);

  localparam int QW = WIDTH + FRAC;
  localparam int CW = (QW > 1) ? $clog2(QW) : 1;
  localparam int IW = (MAX_NEURONS > 1) ? $clog2(MAX_NEURONS) : 1;
  localparam int VW = MAX_NEURONS * WIDTH;
  localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [QW-1:0]    Q_POS   = QW'(POS_MAX);
  localparam logic [QW-1:0]    Q_NEG   = QW'(NEG_MIN);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIV, S_WRITE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [VW-1:0]    va_q, va_d, vb_q, vb_d, out_q, out_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [QW-1:0]    dvd_q, dvd_d, quot_q, quot_d;
  logic [WIDTH-1:0] dvs_q, dvs_d, rem_q, rem_d;
  logic             busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] a_sel, b_sel, res;
  logic [WIDTH:0]   rem_sh;
  logic             sgn;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < MAX_NEURONS; i++) begin
      if (idx_q == IW'(i)) begin
        a_sel = va_q[i*WIDTH +: WIDTH];
        b_sel = vb_q[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    va_d    = va_q;
    vb_d    = vb_q;
    out_d   = out_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    quot_d  = quot_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    res     = '0;
    rem_sh  = {rem_q, dvd_q[QW-1]};
    sgn     = a_sel[WIDTH-1] ^ b_sel[WIDTH-1];
    busy_d  = (state_q == S_LOAD) || (state_q == S_DIV) || (state_q == S_WRITE);
    done_d  = (state_q == S_DONE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          va_d    = vector1;
          vb_d    = vector2;
          ovf_d   = 1'b0;
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        dvd_d   = QW'(a_sel[WIDTH-1] ? -a_sel : a_sel) << FRAC;
        dvs_d   = b_sel[WIDTH-1] ? -b_sel : b_sel;
        rem_d   = '0;
        quot_d  = '0;
        cnt_d   = '0;
        state_d = S_DIV;
      end
      S_DIV: begin
        dvd_d = dvd_q << 1;
        // The remainder stays below the divisor, so dropping the top bit after subtracting is exact.
        if (rem_sh >= {1'b0, dvs_q}) begin
          rem_d  = rem_sh[WIDTH-1:0] - dvs_q;
          quot_d = {quot_q[QW-2:0], 1'b1};
        end else begin
          rem_d  = rem_sh[WIDTH-1:0];
          quot_d = {quot_q[QW-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(QW - 1)) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (b_sel == '0) begin
          if (a_sel != '0) begin
            res   = a_sel[WIDTH-1] ? NEG_MIN : POS_MAX;
            ovf_d = 1'b1;
          end
        end else if (!sgn && (quot_q > Q_POS)) begin
          res   = POS_MAX;
          ovf_d = 1'b1;
        end else if (sgn && (quot_q > Q_NEG)) begin
          res   = NEG_MIN;
          ovf_d = 1'b1;
        end else begin
          res = sgn ? -quot_q[WIDTH-1:0] : quot_q[WIDTH-1:0];
        end
        for (int i = 0; i < MAX_NEURONS; i++) begin
          if (idx_q == IW'(i)) out_d[i*WIDTH +: WIDTH] = res;
        end
        if (idx_q == IW'(MAX_NEURONS - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      va_q    <= '0;
      vb_q    <= '0;
      out_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      dvd_q   <= '0;
      quot_q  <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      va_q    <= va_d;
      vb_q    <= vb_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      quot_q  <= quot_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out      = out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule
